// File: rtl/aec_expr_tx.sv
// AEC expression transmitter: buffers host tokens up to '=', streams them as
// ASCII to the evaluator, then returns the evaluator result to the host.
// Ports: clk, rst (async, active low); tok_valid/tok_data/tok_ready host in;
//   ascii_out/aec_ready to evaluator; aec_valid/aec_result from evaluator;
//   res_valid/res_data host result; busy (not COLLECT); err (sticky).
// Option: define AEC_TX_TIMEOUT_EN to enable the WAIT_RES watchdog.
module aec_expr_tx #(
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tok_valid,
  input  logic [4:0] tok_data,
  output logic       tok_ready,
  output logic [7:0] ascii_out,
  output logic       aec_ready,
  input  logic       aec_valid,
  input  logic [6:0] aec_result,
  output logic       res_valid,
  output logic [6:0] res_data,
  output logic       busy,
  output logic       err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_SEND    = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_GAP     = 2'd3;

  localparam logic [4:0] T_EQ = 5'd21;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH - 1);

  if (DEPTH < 4 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("aec_expr_tx: DEPTH must be >= 4 and TIMEOUT_CYC >= 1");
  end

  logic [1:0]    state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [7:0]    ascii_q, ascii_d;
  logic          aec_ready_q, aec_ready_d;
  logic          tok_ready_q, tok_ready_d;
  logic          res_valid_q, res_valid_d;
  logic [6:0]    res_data_q, res_data_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          buf_we;
  logic [4:0]    buf_q [DEPTH];

`ifdef AEC_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  function automatic logic [7:0] tok2ascii(input logic [4:0] t);
    logic [7:0] a;
    a = 8'h00;
    if (t < 5'd10)      a = 8'h30 + {3'b000, t};
    else if (t < 5'd16) a = 8'h57 + {3'b000, t};
    else begin
      case (t)
        5'd16:   a = 8'h2B;
        5'd17:   a = 8'h2D;
        5'd18:   a = 8'h2A;
        5'd19:   a = 8'h28;
        5'd20:   a = 8'h29;
        5'd21:   a = 8'h3D;
        default: a = 8'h00;
      endcase
    end
    return a;
  endfunction

  logic is_ill, is_eq, is_full, tok_acc;
  assign is_ill  = tok_data > T_EQ;
  assign is_eq   = tok_data == T_EQ;
  assign is_full = cnt_q == FULL;
  assign tok_acc = tok_valid && tok_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    ascii_d     = ascii_q;
    aec_ready_d = 1'b0;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    err_d       = err_q;
    buf_we      = 1'b0;
`ifdef AEC_TX_TIMEOUT_EN
    tmo_d = (state_q == S_WAIT) ? tmo_q + 1'b1 : '0;
`endif
    unique case (state_q)
      S_COLLECT: begin
        if (tok_acc) begin
          // Last slot stays reserved for '=' so the buffer always terminates.
          unique case (1'b1)
            (is_ill || (!is_eq && is_full)): err_d = 1'b1;
            is_eq: begin
              if (cnt_q != '0) begin
                buf_we      = 1'b1;
                cnt_d       = cnt_q + 1'b1;
                state_d     = S_SEND;
                ascii_d     = tok2ascii(buf_q[0]);
                aec_ready_d = 1'b1;
                rd_d        = AW'(1);
              end
            end
            (!is_ill && !is_eq && !is_full): begin
              buf_we = 1'b1;
              cnt_d  = cnt_q + 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_SEND: begin
        if (ascii_q == 8'h3D) begin
          ascii_d = 8'h00;
          state_d = S_WAIT;
          cnt_d   = '0;
          rd_d    = '0;
        end else begin
          ascii_d = tok2ascii(buf_q[rd_q]);
          rd_d    = rd_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (aec_valid) begin
          res_data_d  = aec_result;
          res_valid_d = 1'b1;
          state_d     = S_GAP;
        end
`ifdef AEC_TX_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          res_data_d  = 7'h7F;
          res_valid_d = 1'b1;
          err_d       = 1'b1;
          state_d     = S_GAP;
        end
`endif
      end
      S_GAP:   state_d = S_COLLECT;
      default: state_d = S_COLLECT;
    endcase
    tok_ready_d = state_d == S_COLLECT;
    busy_d      = state_d != S_COLLECT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_COLLECT;
      cnt_q       <= '0;
      rd_q        <= '0;
      ascii_q     <= 8'h00;
      aec_ready_q <= 1'b0;
      tok_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= 7'h00;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef AEC_TX_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      ascii_q     <= ascii_d;
      aec_ready_q <= aec_ready_d;
      tok_ready_q <= tok_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
`ifdef AEC_TX_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= 5'd0;
    end else if (buf_we) begin
      buf_q[cnt_q[AW-1:0]] <= tok_data;
    end
  end

  assign tok_ready = tok_ready_q;
  assign ascii_out = ascii_q;
  assign aec_ready = aec_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_aec_expr_tx.sv
// Scoreboard bench for aec_expr_tx: directed token vectors, expected ASCII
// stream and results queued at stimulus time, checked by a monitor process.
module tb_aec_expr_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tok_valid = 1'b0;
  logic [4:0] tok_data = 5'd0;
  logic       tok_ready;
  logic [7:0] ascii_out;
  logic       aec_ready;
  logic       aec_valid = 1'b0;
  logic [6:0] aec_result = 7'd0;
  logic       res_valid;
  logic [6:0] res_data;
  logic       busy;
  logic       err;

  aec_expr_tx #(.DEPTH(16), .TIMEOUT_CYC(10)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_data(tok_data), .tok_ready(tok_ready),
    .ascii_out(ascii_out), .aec_ready(aec_ready),
    .aec_valid(aec_valid), .aec_result(aec_result),
    .res_valid(res_valid), .res_data(res_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_ch [$];
  logic [6:0] exp_res [$];
  logic [7:0] ec [$];
  int stim [$];
  bit sending = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic mon_step();
    logic [8:0] e;
    logic [6:0] r;
    @(negedge clk);
    if (rst) begin
      if (ascii_out != 8'h00) begin
        if (exp_ch.size() == 0) chk("unexpected_char", int'(ascii_out), 0);
        else begin
          e = exp_ch.pop_front();
          chk("ascii", int'(ascii_out), int'(e[7:0]));
          chk("aec_ready", int'(aec_ready), int'(e[8]));
          chk("tok_ready_send", int'(tok_ready), 0);
          sending = exp_ch.size() != 0;
        end
      end else begin
        if (sending) chk("bubble", int'(ascii_out), int'(exp_ch[0][7:0]));
        sending = 1'b0;
        if (aec_ready) chk("aec_ready_idle", int'(aec_ready), 0);
      end
      if (res_valid) begin
        if (exp_res.size() == 0) chk("unexpected_res", int'(res_valid), 0);
        else begin
          r = exp_res.pop_front();
          chk("res_data", int'(res_data), int'(r));
          chk("tok_ready_gap", int'(tok_ready), 0);
          chk("busy_gap", int'(busy), 1);
        end
      end
    end
  endtask

  task automatic push_chars();
    for (int i = 0; i < ec.size(); i++)
      exp_ch.push_back({(i == 0), ec[i]});
  endtask

  task automatic send_tok(input int d);
    int n;
    n = 0;
    tok_valid = 1'b1;
    tok_data  = 5'(d);
    while (!tok_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("tok_ready_wait", int'(tok_ready), 1);
    @(posedge clk); #1;
    tok_valid = 1'b0;
  endtask

  task automatic send_stim();
    for (int i = 0; i < stim.size(); i++) send_tok(stim[i]);
  endtask

  task automatic wait_chars();
    int n;
    n = 0;
    while (exp_ch.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("char_wait", exp_ch.size(), 0);
  endtask

  task automatic wait_res();
    int n;
    n = 0;
    while (exp_res.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) chk("res_wait", exp_res.size(), 0);
  endtask

  task automatic respond(input logic [6:0] r);
    wait_chars();
    exp_res.push_back(r);
    aec_valid  = 1'b1;
    aec_result = r;
    @(posedge clk); #1;
    aec_valid  = 1'b0;
    wait_res();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      forever mon_step();
    join_none

    #2 rst = 1'b0;
    #1;
    chk("rst_tok_ready", int'(tok_ready), 0);
    chk("rst_ascii", int'(ascii_out), 0);
    chk("rst_aec_ready", int'(aec_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    #19 rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_tok_ready", int'(tok_ready), 1);

    ec = '{8'h33, 8'h2B, 8'h34, 8'h3D};
    push_chars();
    stim = '{3, 16, 4, 21};
    send_stim();
    chk("first_char_latency", int'(aec_ready), 1);
    chk("busy_send", int'(busy), 1);
    respond(7'd7);
    chk("t1_err", int'(err), 0);
    chk("t1_tok_ready", int'(tok_ready), 1);
    chk("t1_busy", int'(busy), 0);

    ec = '{8'h28, 8'h61, 8'h2D, 8'h32, 8'h29, 8'h2A, 8'h66, 8'h3D};
    push_chars();
    stim = '{19, 10, 17, 2, 20, 18, 15, 21};
    send_stim();
    respond(7'h55);
    chk("t2_tok_ready", int'(tok_ready), 1);

    send_tok(21);
    repeat (3) @(posedge clk);
    #1;
    chk("lone_eq_tok_ready", int'(tok_ready), 1);
    chk("lone_eq_busy", int'(busy), 0);
    chk("lone_eq_err", int'(err), 0);
    send_tok(25);
    chk("illegal_err", int'(err), 1);

    ec = '{8'h31, 8'h2B, 8'h32, 8'h3D};
    push_chars();
    stim = '{1, 16, 2, 21};
    send_stim();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_ascii", int'(ascii_out), 0);
    chk("midrst_aec_ready", int'(aec_ready), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_err", int'(err), 0);
    exp_ch.delete();
    sending = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_tok_ready", int'(tok_ready), 1);

    ec = '{8'h35, 8'h3D};
    push_chars();
    stim = '{5, 21};
    send_stim();
    respond(7'h0C);

    ec.delete();
    stim.delete();
    for (int i = 0; i < 15; i++) begin
      ec.push_back(8'h31);
      stim.push_back(1);
    end
    ec.push_back(8'h3D);
    push_chars();
    send_stim();
    chk("full_err_before", int'(err), 0);
    send_tok(16);
    chk("full_err_after", int'(err), 1);
    send_tok(21);
    respond(7'h02);

`ifdef AEC_TX_TIMEOUT_EN
    ec = '{8'h39, 8'h3D};
    push_chars();
    stim = '{9, 21};
    send_stim();
    wait_chars();
    exp_res.push_back(7'h7F);
    wait_res();
    chk("tmo_err", int'(err), 1);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("chars_drained", exp_ch.size(), 0);
    chk("res_drained", exp_res.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
